// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the CPU instruction memory.
// Receives a framed program (length header, big-endian 16-bit words, trailing
// checksum). It writes each word to the IM write port and holds the CPU in
// reset until a frame has loaded cleanly.
module imem_loader #(
  parameter int IM_DEPTH = 4096,
  parameter int ADDR_W   = $clog2(IM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [15:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  // The word count is 17 bits wide so that any 16-bit header value compares
  // cleanly against the memory depth.
  localparam logic [16:0] MAX_WORDS = 17'(IM_DEPTH);

  state_t            state_reg, state_next;
  logic [7:0]        len_hi_reg;
  logic [7:0]        hi_byte_reg;
  logic [7:0]        csum_reg;
  logic [16:0]       word_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic        accept;
  logic        can_start;
  logic [16:0] len_word;
  logic [7:0]  csum_final;

  assign accept     = s_valid && s_ready;
  assign can_start  = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                state_reg == S_ERR);
  assign len_word   = {1'b0, len_hi_reg, s_data};
  assign csum_final = csum_reg + s_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. The handshake and status outputs decode only the
  // registered state, so s_ready never depends on s_valid.
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst_n  = 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        s_ready = 1'b1; busy = 1'b1; cpu_rst_n = 1'b0;
        if (accept) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        s_ready = 1'b1; busy = 1'b1; cpu_rst_n = 1'b0;
        if (accept) begin
          if (len_word == 17'd0)          state_next = S_CSUM;
          else if (len_word > MAX_WORDS)  state_next = S_ERR;
          else                            state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        s_ready = 1'b1; busy = 1'b1; cpu_rst_n = 1'b0;
        if (accept) state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        s_ready = 1'b1; busy = 1'b1; cpu_rst_n = 1'b0;
        if (accept) state_next = (word_cnt_reg == 17'd1) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        s_ready = 1'b1; busy = 1'b1; cpu_rst_n = 1'b0;
        if (accept) state_next = (csum_final == 8'd0) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      S_ERR: begin
        err = 1'b1; cpu_rst_n = 1'b0;
        if (start) state_next = S_LEN_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, checksum and registered IM port.
  // A start and a byte accept can never coincide because bytes are only
  // accepted in the in-session states where start is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_reg   <= 8'd0;
      hi_byte_reg  <= 8'd0;
      csum_reg     <= 8'd0;
      word_cnt_reg <= 17'd0;
      addr_reg     <= '0;
      im_we        <= 1'b0;
      im_waddr     <= '0;
      im_wdata     <= 16'd0;
    end else begin
      im_we <= 1'b0;
      if (can_start) begin
        csum_reg <= 8'd0;
        addr_reg <= '0;
      end
      if (accept) begin
        case (state_reg)
          S_LEN_HI:  len_hi_reg   <= s_data;
          S_LEN_LO:  word_cnt_reg <= len_word;
          S_DATA_HI: begin
            hi_byte_reg <= s_data;
            csum_reg    <= csum_final;
          end
          S_DATA_LO: begin
            im_we        <= 1'b1;
            im_waddr     <= addr_reg;
            im_wdata     <= {hi_byte_reg, s_data};
            addr_reg     <= addr_reg + ADDR_W'(1);
            word_cnt_reg <= word_cnt_reg - 17'd1;
            csum_reg     <= csum_final;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames plus randomized frames checked against a
// frame-parsing reference model, and reset / mid-frame start corner cases.
module tb_imem_loader;
  localparam int IM_DEPTH = 4096;
  localparam int ADDR_W   = 12;

  logic              clk = 1'b0;
  logic              rst, start, s_valid, s_ready;
  logic [7:0]        s_data;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [15:0]       im_wdata;
  logic              cpu_rst_n, busy, done, err;

  imem_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef logic [15:0] hq_t[$];

  typedef struct {
    logic [15:0] len;
    logic [15:0] w0, w1, w2;
    logic [7:0]  csum;
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  int  tests  = 0;
  int  failed = 0;
  wq_t got;

  // Record every IM write seen, one entry per cycle with im_we high.
  always @(negedge clk) if (im_we) got.push_back({4'h0, im_waddr, im_wdata});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: parse the frame as a list of bytes.
  function automatic void model(input bq_t b, output wq_t w, output bit ok, output bit len_bad);
    int         n;
    logic [7:0] sum;
    w = {};
    ok = 1'b0;
    n = int'({b[0], b[1]});
    len_bad = (n > IM_DEPTH);
    if (len_bad) return;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w.push_back({4'h0, 12'(i), b[2 + 2*i], b[3 + 2*i]});
      sum = sum + b[2 + 2*i] + b[3 + 2*i];
    end
    ok = ((sum + b[2 + 2*n]) == 8'd0);
  endfunction

  function automatic void build(input logic [15:0] len, input hq_t ws,
                                input logic [7:0] csum, output bq_t b);
    b = {};
    b.push_back(len[15:8]);
    b.push_back(len[7:0]);
    foreach (ws[i]) begin
      b.push_back(ws[i][15:8]);
      b.push_back(ws[i][7:0]);
    end
    b.push_back(csum);
  endfunction

  function automatic logic [7:0] good_csum(input hq_t ws);
    logic [7:0] s = 8'd0;
    foreach (ws[i]) s = s + ws[i][15:8] + ws[i][7:0];
    return 8'd0 - s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".s_ready"},   s_ready,   0);
    check({tag, ".im_we"},     im_we,     0);
    check({tag, ".im_waddr"},  im_waddr,  0);
    check({tag, ".im_wdata"},  im_wdata,  0);
    check({tag, ".cpu_rst_n"}, cpu_rst_n, 1);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".done"},      done,      0);
    check({tag, ".err"},       err,       0);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    got.delete();
    check({tag, ".start_busy"},  busy,      1);
    check({tag, ".start_cpurn"}, cpu_rst_n, 0);
    check({tag, ".start_ready"}, s_ready,   1);
    check({tag, ".start_flags"}, {done, err}, 2'b00);
  endtask

  // Offer bytes with random gaps; stops after the last byte is accepted or
  // when the loader stops accepting. Returns at the negedge after the last accept.
  task automatic send(input bq_t b, input int gap_pct, input bit mid_start, output int nacc);
    int idx = 0;
    int cyc = 0;
    bit was_acc = 1'b0;
    bit mid_done = 1'b0;
    while (1) begin
      @(negedge clk);
      if (was_acc) idx++;
      start = 1'b0;
      if (idx >= b.size() || !s_ready || cyc >= 30000) break;
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = b[idx];
      if (mid_start && !mid_done && idx == 3) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      was_acc = s_valid && s_ready;
      cyc++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (cyc >= 30000) check("send_timeout", 1, 0);
    nacc = idx;
  endtask

  task automatic run_frame(input string tag, input bq_t b, input int gap, input bit mid,
                           input bit use_tab, input bit tab_done, input bit tab_err,
                           input int tab_nw);
    wq_t exp_w;
    bit  ok, len_bad, exp_done, exp_err;
    int  nacc, exp_nw, nmin;
    do_start(tag);
    send(b, gap, mid, nacc);
    model(b, exp_w, ok, len_bad);
    exp_done = use_tab ? tab_done : (ok && !len_bad);
    exp_err  = use_tab ? tab_err  : !(ok && !len_bad);
    exp_nw   = use_tab ? tab_nw   : exp_w.size();
    check({tag, ".done"},      done,      exp_done);
    check({tag, ".err"},       err,       exp_err);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".cpu_rst_n"}, cpu_rst_n, exp_done);
    check({tag, ".s_ready"},   s_ready,   0);
    if (len_bad) check({tag, ".bytes_taken"}, nacc, 2);
    @(negedge clk);
    check({tag, ".done_held"}, {done, err}, {exp_done, exp_err});
    check({tag, ".nwrites"}, got.size(), exp_nw);
    nmin = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < nmin; i++) begin
      tests++;
      if (got[i] !== exp_w[i]) begin
        failed++;
        $display("FAIL %s.write[%0d]: got addr/data 0x%0h, expected 0x%0h",
                 tag, i, got[i], exp_w[i]);
        break;
      end
    end
    $display("[TB] %s: N=0x%0h writes=%0d done=%0b err=%0b", tag,
             {b[0], b[1]}, got.size(), done, err);
  endtask

  initial begin
    vec_t tab[7];
    bq_t  b;
    hq_t  ws;
    int   nacc;

    tab[0] = '{16'h0002, 16'h3A05, 16'h1203, 16'h0000, 8'hAC, 1, 0, 2};
    tab[1] = '{16'h0002, 16'h3A05, 16'h1203, 16'h0000, 8'hAD, 0, 1, 2};
    tab[2] = '{16'h1001, 16'h1111, 16'h2222, 16'h3333, 8'h00, 0, 1, 0};
    tab[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1, 0, 0};
    tab[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h01, 0, 1, 0};
    tab[5] = '{16'h0003, 16'h0102, 16'hA0FF, 16'h7E00, 8'hE0, 1, 0, 3};
    tab[6] = '{16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC, 8'h00, 0, 1, 0};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Table-driven frames, gap-free.
    for (int t = 0; t < 7; t++) begin
      ws = {};
      if (tab[t].len >= 1) ws.push_back(tab[t].w0);
      if (tab[t].len >= 2) ws.push_back(tab[t].w1);
      if (tab[t].len >= 3) ws.push_back(tab[t].w2);
      build(tab[t].len, ws, tab[t].csum, b);
      run_frame($sformatf("tab%0d", t), b, 0, 1'b0, 1'b1,
                tab[t].exp_done, tab[t].exp_err, tab[t].exp_nw);
    end

    // 3-word frame with random gaps and a start pulse mid-frame.
    ws = {tab[5].w0, tab[5].w1, tab[5].w2};
    build(tab[5].len, ws, tab[5].csum, b);
    run_frame("gaps_midstart", b, 40, 1'b1, 1'b1, 1, 0, 3);

    // Randomized frames against the model.
    for (int it = 0; it < 10; it++) begin
      int n;
      logic [7:0] cs;
      n = $urandom_range(1, 6);
      ws = {};
      for (int k = 0; k < n; k++) ws.push_back(16'($urandom));
      cs = good_csum(ws);
      if ($urandom_range(1) == 1) cs = cs + 8'(1 + $urandom_range(254));
      build(16'(n), ws, cs, b);
      run_frame($sformatf("rand%0d", it), b, 30, it[0], 1'b0, 0, 0, 0);
    end

    // Full-depth load.
    ws = {};
    for (int k = 0; k < IM_DEPTH; k++) ws.push_back(16'($urandom));
    build(16'(IM_DEPTH), ws, good_csum(ws), b);
    run_frame("full_depth", b, 0, 1'b0, 1'b0, 0, 0, 0);

    // Reset while in DATA_LO, then a fresh load from address 0.
    do_start("rst_mid");
    b = {8'h00, 8'h03, 8'h11};
    send(b, 0, 1'b0, nacc);
    check("rst_mid.in_data_lo", s_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    ws = {tab[0].w0, tab[0].w1};
    build(tab[0].len, ws, tab[0].csum, b);
    run_frame("after_rst", b, 0, 1'b0, 1'b1, 1, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side program loader that writes the CPU instruction memory over a byte stream, replacing the compile-time `IM_FILE` preload for FPGA bring-up. It holds the CPU in reset while loading. It assembles big-endian 16-bit instruction words and drives the IM write port. It checks a length header and a trailing checksum, then releases the CPU so that `cpu_top` starts from address 0 with the new program.

## Interface
- `IM_DEPTH`, 4096, instruction-memory depth in 16-bit words; legal word counts are 0..`IM_DEPTH`.
- `ADDR_W`, `$clog2(IM_DEPTH)`, IM write-address width.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load session. Ignored unless the state is IDLE, DONE or ERR.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  loader accepts a byte. A byte transfers on any cycle where `s_valid && s_ready`.
- `s_data`  in  8  input byte.
- `im_we`  out  1  IM write strobe, one cycle per word.
- `im_waddr`  out  `ADDR_W`  IM word address.
- `im_wdata`  out  16  IM write data.
- `cpu_rst_n`  out  1  active-low reset to `cpu_top`.
- `busy`  out  1  high while a session is in progress.
- `done`  out  1  high after a successful load; held until the next `start` or `rst`.
- `err`  out  1  high after a failed load; held until the next `start` or `rst`.

## Operation
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then N × (DATA_HI, DATA_LO), then CSUM.
- The checksum is valid when (sum of all 2N data bytes + CSUM) mod 256 == 0. The length bytes are not included in the sum.
- States and transitions:
  - IDLE --`start`--> LEN_HI.
  - LEN_HI --byte--> LEN_LO.
  - LEN_LO --byte--> DATA_HI if 1 ≤ N ≤ `IM_DEPTH`; CSUM if N == 0; ERR if N > `IM_DEPTH`.
  - DATA_HI --byte--> DATA_LO.
  - DATA_LO --byte--> DATA_HI if words remain; otherwise CSUM.
  - CSUM --byte--> DONE if the sum is 0 mod 256; otherwise ERR.
  - DONE and ERR --`start`--> LEN_HI.
- `s_ready` is 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM. It is decoded from the registered state only and never depends on `s_valid`.
- Data bytes: the byte accepted in DATA_HI is latched as the high byte. Accepting the DATA_LO byte forms the 16-bit word and schedules one IM write.
- Addressing: the write address starts at 0 for each session and increments by 1 after each write. The address never wraps because N is limited to `IM_DEPTH`.
- Word counter: 17 bits wide (N up to 65535 is compared against `IM_DEPTH`). It is loaded with N in LEN_LO and decremented on each DATA_LO accept.
- Checksum accumulator: 8-bit, cleared on `start`, wraps modulo 256.
- `cpu_rst_n` is driven low on `start` and stays low through the whole session and in ERR. It returns high on entry to DONE.
- Words written before an ERR remain in IM. The CPU stays in reset, so a partial program is never executed.
- A `start` pulse while in LEN_HI..CSUM is ignored. It does not restart the session.
- `s_valid` low stalls the FSM in its current state with no side effects.

## Timing
- Reset values: state IDLE, `s_ready`=0, `im_we`=0, `im_waddr`=0, `im_wdata`=0, `cpu_rst_n`=1, `busy`=0, `done`=0, `err`=0.
- After reset `cpu_rst_n`=1, so a CPU with a preloaded IM runs without the loader.
- `rst` asserted mid-session returns every output to its reset value on the next edge. Partially written IM contents are left in place.
- `start` at edge t: state is LEN_HI, `busy`=1, `cpu_rst_n`=0, and `done`/`err`=0 from cycle t+1.
- Minimum byte throughput is one byte per cycle when `s_valid` is held high.
- `im_we`, `im_waddr` and `im_wdata` are registered. `im_we` pulses high for exactly one cycle, in the cycle after the DATA_LO accept, with `im_waddr` equal to the word index.
- CSUM accept at edge t: `done` or `err` goes high and `busy` goes low at t+1. On success `cpu_rst_n` also goes high at t+1.
- No more than one `im_we` pulse occurs per two accepted data bytes. No IM write occurs after the last DATA_LO byte.

## Test plan
- Load N=2 with words 0x3A05 and 0x1203, CSUM = −(0x3A+0x05+0x12+0x03) mod 256 = 0xAC:
  - `im_we` pulses at addr 0 with data 0x3A05, then at addr 1 with data 0x1203.
  - `done`=1 and `cpu_rst_n` rises one cycle after the CSUM accept.
- Same frame with CSUM 0xAD -> both IM writes occur, then `err`=1, `done`=0 and `cpu_rst_n` stays 0.
- LEN = 0x1001 (4097, with `IM_DEPTH`=4096) -> ERR right after the LEN_LO accept, `s_ready`=0 and no `im_we`.
- N=0 with CSUM 0x00 -> DONE with no writes. N=0 with CSUM 0x01 -> ERR.
- Random `s_valid` gaps and a `start` pulse mid-frame on a 3-word load -> writes are identical to the gap-free case and the session is not restarted.
- Assert `rst` for one cycle while in DATA_LO -> all outputs return to reset values, including `cpu_rst_n`=1. A following fresh `start` and a full frame load correctly from addr 0.
